// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_stream_pkg;

   localparam int DW         = 32;
   localparam int MISS_CNT_W = 16;

   typedef enum logic {
      RUN,
      BACKOFF
   } drain_state_t;

endpackage

// File: rtl/fifo_stream_drain_skid.sv
// Two-entry, order-preserving valid/ready holding buffer.
// ent0 is always the head. A push and a pop in the same cycle leave the
// occupancy unchanged.
module stream_skid2 #(
   parameter int DW = fifo_stream_pkg::DW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] head,
   output logic [1:0]    count
);
   import fifo_stream_pkg::*;

   logic [DW-1:0] ent0;
   logic [DW-1:0] ent1;

   assign valid = (count != 2'd0);
   assign head  = ent0;

   // Entry storage and occupancy; a pop shifts ent1 forward into the head slot
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent0  <= '0;
         ent1  <= '0;
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= push_data;
               else               ent1 <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Popping requires count >= 1, so only the 1- and 2-entry cases exist here
               if (count == 2'd1) begin
                  ent0 <= push_data;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_drain.sv
// Read-side adapter for a sync FIFO with a registered read port: issues
// reads, resolves hits/misses a cycle later, backs off after a miss and
// frames the resulting stream into fixed-length packets.
module fifo_stream_drain #(
   parameter int DW      = fifo_stream_pkg::DW,
   parameter int PKT_LEN = 16,
   parameter int BACKOFF = 4
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   output logic                                  fifo_re,
   input  logic [DW-1:0]                         fifo_dout,
   input  logic                                  fifo_empty,
   output logic                                  m_valid,
   input  logic                                  m_ready,
   output logic [DW-1:0]                         m_data,
   output logic                                  m_last,
   output logic [fifo_stream_pkg::MISS_CNT_W-1:0] miss_cnt
);
   import fifo_stream_pkg::*;

   localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
   localparam logic [15:0] BO_LOAD   = (BACKOFF > 0) ? 16'(BACKOFF - 1) : 16'd0;

   drain_state_t state;
   drain_state_t state_nxt;
   logic [15:0]  bo_cnt;
   logic [15:0]  bo_cnt_nxt;
   logic         inflight;
   logic         pop;
   logic         hit;
   logic         miss;
   logic [1:0]   count;
   logic [2:0]   occ;
   logic [15:0]  beat_cnt;

   assign pop  = m_valid & m_ready;
   assign hit  = inflight & ~fifo_empty;
   assign miss = inflight & fifo_empty;
   // Projected skid occupancy once everything already requested has landed
   assign occ  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

   // FSM state and backoff countdown
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= RUN;
         bo_cnt <= '0;
      end else begin
         state  <= state_nxt;
         bo_cnt <= bo_cnt_nxt;
      end
   end

   // Next state and read strobe; m_ready feeds fifo_re directly so a pop
   // frees a slot for a new read in the same cycle
   always_comb begin
      state_nxt  = state;
      bo_cnt_nxt = bo_cnt;
      fifo_re    = 1'b0;
      case (state)
         RUN: begin
            // Gated by rstn so the strobe is low while reset is held
            fifo_re = rstn && (occ < 3'd2);
            if (miss && (BACKOFF != 0)) begin
               state_nxt  = fifo_stream_pkg::BACKOFF;
               bo_cnt_nxt = BO_LOAD;
            end
         end
         fifo_stream_pkg::BACKOFF: begin
            if (bo_cnt == 16'd0) state_nxt = RUN;
            else                 bo_cnt_nxt = bo_cnt - 16'd1;
         end
         default: state_nxt = RUN;
      endcase
   end

   // Read-in-flight tracking and saturating miss counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight <= 1'b0;
         miss_cnt <= '0;
      end else begin
         inflight <= fifo_re;
         if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
   end

   // Packet position; wraps after the beat flagged last
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       beat_cnt <= '0;
      else if (pop)    beat_cnt <= m_last ? 16'd0 : beat_cnt + 16'd1;
   end

   assign m_last = m_valid && (beat_cnt == LAST_BEAT);

   stream_skid2 #(.DW(DW)) u_skid (
      .clk       (clk),
      .rstn      (rstn),
      .push      (hit),
      .push_data (fifo_dout),
      .pop       (pop),
      .valid     (m_valid),
      .head      (m_data),
      .count     (count)
   );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural registered-read FIFO.
module tb_fifo_stream_drain;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          fifo_re;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [15:0]   miss_cnt;

   // second instance: single-beat packets, always-hit source
   logic          re1;
   logic          valid1;
   logic [DW-1:0] data1;
   logic          last1;
   logic [15:0]   miss1;
   logic [DW-1:0] dout1 = 32'h5A;
   logic          empty1 = 1'b0;
   logic          ready1 = 1'b1;

   int n_chk = 0;
   int n_pass = 0;

   logic [DW-1:0] mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr;

   always #5 clk = ~clk;

   fifo_stream_drain #(.DW(DW), .PKT_LEN(16), .BACKOFF(4)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .fifo_re    (fifo_re),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .miss_cnt   (miss_cnt)
   );

   fifo_stream_drain #(.DW(DW), .PKT_LEN(1), .BACKOFF(4)) u_dut1 (
      .clk        (clk),
      .rstn       (rstn),
      .fifo_re    (re1),
      .fifo_dout  (dout1),
      .fifo_empty (empty1),
      .m_valid    (valid1),
      .m_ready    (ready1),
      .m_data     (data1),
      .m_last     (last1),
      .miss_cnt   (miss1)
   );

   // FIFO model: registered read, empty pulse after a read of an empty FIFO, dout holds on miss
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr     <= 0;
         fifo_dout  <= '0;
         fifo_empty <= 1'b0;
      end else if (fifo_re) begin
         if (rd_ptr != wr_ptr) begin
            fifo_dout  <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
            fifo_empty <= 1'b0;
         end else begin
            fifo_empty <= 1'b1;
         end
      end else begin
         fifo_empty <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic push_word(input logic [31:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr++;
   endtask

   // Hold reset across a few edges; returns at a falling edge with rstn still low
   task automatic do_reset();
      rstn    = 1'b0;
      m_ready = 1'b0;
      wr_ptr  = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  idx;
      bit  prev_stall;
      logic [31:0] prev_data;
      logic prev_last;

      m_ready = 1'b0;
      do_reset();
      #1;
      check("rst_fifo_re",  32'(fifo_re),  32'd0);
      check("rst_m_valid",  32'(m_valid),  32'd0);
      check("rst_m_data",   m_data,        32'd0);
      check("rst_m_last",   32'(m_last),   32'd0);
      check("rst_miss_cnt", 32'(miss_cnt), 32'd0);

      // 16 preloaded words, always ready: beats on consecutive cycles from cycle 2
      @(negedge clk);
      for (int i = 0; i < 16; i++) push_word(32'(i));
      m_ready = 1'b1;
      rstn    = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (c == 0) check("first_re", 32'(fifo_re), 32'd1);
         check("b_valid", 32'(m_valid), 32'(c >= 2));
         check("len1_valid", 32'(valid1), 32'(c >= 2));
         check("len1_last",  32'(last1),  32'(c >= 2));
         if (c >= 2) begin
            check("b_data", m_data, 32'(c - 2));
            check("b_last", 32'(m_last), 32'(c == 17));
         end
      end
      @(negedge clk);
      #1;
      check("b_drained", 32'(m_valid), 32'd0);

      // Same preload, m_ready toggling: order, stall stability, no loss or duplication
      do_reset();
      for (int i = 0; i < 16; i++) push_word(32'(i));
      rstn = 1'b1;
      idx = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      for (int c = 0; c < 100 && idx < 16; c++) begin
         if (c > 0) @(negedge clk);
         m_ready = (c % 2 == 0);
         #1;
         if (prev_stall) begin
            check("c_hold_valid", 32'(m_valid), 32'd1);
            check("c_hold_data",  m_data,       prev_data);
            check("c_hold_last",  32'(m_last),  32'(prev_last));
         end
         if (m_valid && m_ready) begin
            check("c_data", m_data, 32'(idx));
            check("c_last", 32'(m_last), 32'(idx == 15));
            idx++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
      check("c_beats", 32'(idx), 32'd16);
      repeat (3) @(negedge clk);
      #1;
      check("c_no_dup", 32'(m_valid), 32'd0);

      // 40 beats, PKT_LEN 16: last on beats 15 and 31, position 8 at the end
      do_reset();
      for (int i = 0; i < 40; i++) push_word(32'h100 + 32'(i));
      m_ready = 1'b1;
      rstn = 1'b1;
      idx = 0;
      for (int c = 0; c < 120 && idx < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (m_valid && m_ready) begin
            check("d_data", m_data, 32'h100 + 32'(idx));
            check("d_last", 32'(m_last), 32'(idx % 16 == 15));
            idx++;
         end
      end
      check("d_beats", 32'(idx), 32'd40);
      @(negedge clk);
      #1;
      check("d_beat_cnt", 32'(u_dut.beat_cnt), 32'd8);

      // Empty FIFO: probe pairs at 0/1, 6/7, 12/13; three words land mid-backoff
      do_reset();
      m_ready = 1'b1;
      rstn = 1'b1;
      for (int c = 0; c < 28; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 15) begin
            push_word(32'hA0);
            push_word(32'hA1);
            push_word(32'hA2);
         end
         #1;
         if (c < 14)       check("a_re", 32'(fifo_re), 32'((c % 6) < 2));
         else if (c < 18)  check("a_re", 32'(fifo_re), 32'd0);
         else if (c < 23)  check("a_re", 32'(fifo_re), 32'd1);
         else if (c < 27)  check("a_re", 32'(fifo_re), 32'd0);
         else              check("a_re", 32'(fifo_re), 32'd1);
         check("a_valid", 32'(m_valid), 32'(c >= 20 && c <= 22));
         if (c >= 20 && c <= 22) begin
            check("a_data", m_data, 32'hA0 + 32'(c - 20));
            check("a_last", 32'(m_last), 32'd0);
         end
         if (c == 13) check("a_miss13", 32'(miss_cnt), 32'd4);
         if (c == 27) check("a_miss27", 32'(miss_cnt), 32'd8);
      end

      // Reset while the skid is full: everything clears without waiting for a clock
      m_ready = 1'b0;
      push_word(32'hB0);
      push_word(32'hB1);
      push_word(32'hB2);
      push_word(32'hB3);
      repeat (12) @(negedge clk);
      #1;
      check("e_full_valid", 32'(m_valid), 32'd1);
      check("e_full_data",  m_data,       32'hB0);
      check("e_full_miss",  32'(miss_cnt), 32'd8);
      #2;
      rstn = 1'b0;
      #1;
      check("e_rst_valid", 32'(m_valid),  32'd0);
      check("e_rst_data",  m_data,        32'd0);
      check("e_rst_last",  32'(m_last),   32'd0);
      check("e_rst_miss",  32'(miss_cnt), 32'd0);
      check("e_rst_re",    32'(fifo_re),  32'd0);
      wr_ptr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("e_release_re",    32'(fifo_re), 32'd1);
      check("e_release_valid", 32'(m_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
